controle_multiplicador: RTL and testbench
=========================================

CONTROLE_MULTIPLICADOR -- requirements
Module: controle_multiplicador

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; the result is 2*WIDTH bits.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  level request to multiply; held high by the requester until done_o is seen.
REQ-005 SHALL have port A_i  input  WIDTH  multiplicand, unsigned.
REQ-006 SHALL have port B_i  input  WIDTH  multiplier, unsigned.
REQ-007 SHALL have port result_o  output  2*WIDTH  registered product A*B.
REQ-008 SHALL have port busy_o  output  1  high in states LOAD and CALC.
REQ-009 SHALL have port done_o  output  1  high in state DONE only.
REQ-010 SHALL have port fsm_state_o  output  2  debug state code: IDLE=0, LOAD=1, CALC=2, DONE=3.

Function
REQ-011 SHALL implement a shift-add multiplier with internal multiplicand register (2*WIDTH), multiplier register (WIDTH), accumulator (2*WIDTH) and iteration counter (clog2(WIDTH) bits).
REQ-012 IDLE: start_i=1 at an edge -> LOAD; otherwise stay; registers hold.
REQ-013 LOAD: at the edge, multiplicand <= zero-extended A_i, multiplier <= B_i, accumulator <= 0, counter <= 0; -> CALC.
REQ-014 CALC, per edge: if multiplier[0]=1 then accumulator <= accumulator + multiplicand (2*WIDTH-bit add, carry-out discarded; it cannot overflow); multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-015 CALC exit: when counter = WIDTH-1, at that edge -> DONE and result_o <= final accumulator value (including that iteration's add).
REQ-016 Latency: start_i sampled at edge k gives done_o=1 after edge k+1+WIDTH (k+5 for WIDTH=4).
REQ-017 DONE: done_o=1 and result_o holds; start_i=0 at an edge -> IDLE; start_i=1 keeps DONE (no retrigger until start_i drops).
REQ-018 A_i and B_i changes after the LOAD edge SHALL NOT affect the running product.
REQ-019 start_i SHALL be ignored in LOAD and CALC; a deassertion of start_i mid-computation does not abort.
REQ-020 result_o SHALL keep the last product through IDLE until the next DONE entry updates it.
REQ-021 busy_o, done_o and fsm_state_o SHALL be decoded from the state register only (no input-to-output combinational path).

Reset
REQ-022 rst_i=1 at an edge SHALL force state IDLE, result_o=0, accumulator, multiplicand, multiplier and counter = 0; busy_o=0, done_o=0, fsm_state_o=0.
REQ-023 Reset SHALL take priority over every transition, including mid-CALC and in DONE; the aborted product is discarded.
REQ-024 If start_i=1 on the first edge after rst_i falls, the block SHALL enter LOAD on that edge.

Configuration
REQ-025 Macro CONTROLE_MULT_EARLY_EXIT_EN SHALL select early termination.
REQ-026 With CONTROLE_MULT_EARLY_EXIT_EN defined: CALC -> DONE also at the edge where the post-shift multiplier value is 0, with result_o <= the accumulator including that edge's add; latency becomes 2 + (index of highest set bit of B, or 0 if B=0) + 1 edges after start.
REQ-027 Without the macro: CALC always runs exactly WIDTH iterations (REQ-015, REQ-016).
REQ-028 The product value SHALL be identical in both builds.

Verification
REQ-029 A=3, B=5, start_i held -> busy_o high edges k+1..k+5, done_o=1 after edge k+5, result_o=15.
REQ-030 A=15, B=15 -> result_o=225 (8'hE1), no truncation.
REQ-031 A=9, B=0 -> result_o=0; done_o after edge k+2 with CONTROLE_MULT_EARLY_EXIT_EN, after edge k+5 without; A=7, B=1 -> 7, done after edge k+2 with the macro.
REQ-032 A=6, B=4 started, A_i/B_i changed to 15 during CALC -> result_o=24.
REQ-033 rst_i pulsed during the 2nd CALC cycle -> state IDLE, result_o=0 next cycle; with start_i still high, a fresh product is computed.
REQ-034 start_i held 10 cycles in DONE -> remains DONE, no restart; start_i=0 -> IDLE; result_o unchanged.

Source files
------------

// File: rtl/controle_multiplicador.sv
`default_nettype none
// ============================================================================
//  Module      : controle_multiplicador
//  Description : Sequential shift-add unsigned multiplier with a four-state
//                controller (IDLE, LOAD, CALC, DONE) and a level start
//                handshake. The product is 2*WIDTH bits wide and is held
//                in a result register until the next completion.
//                Optional early termination is enabled by defining the
//                macro CONTROLE_MULT_EARLY_EXIT_EN. With early termination,
//                CALC ends as soon as the remaining multiplier bits are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_multiplicador #(
    parameter int WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     A_i,
    input  logic [WIDTH-1:0]     B_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           fsm_state_o
);

    // Iteration counter is at least one bit wide so WIDTH=1 still elaborates
    localparam int                 c_CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_result;

    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last_iter;

    // Partial product for this iteration; carry-out cannot occur
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

`ifdef CONTROLE_MULT_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain after this iteration's shift
    assign w_last_iter = (r_cnt == c_LAST) || ((r_mplier >> 1) == '0);
`else
    assign w_last_iter = (r_cnt == c_LAST);
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start_i only matters in IDLE and DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i)     w_state_next = S_LOAD;
            S_LOAD:                   w_state_next = S_CALC;
            S_CALC:  if (w_last_iter) w_state_next = S_DONE;
            S_DONE:  if (!start_i)    w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operands captured in LOAD, one shift-add step per CALC edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_mcand  <= {{WIDTH{1'b0}}, A_i};
                    r_mplier <= B_i;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_CNT_ONE;
                    if (w_last_iter) begin
                        r_result <= w_acc_next;
                    end
                end
                default: begin
                    // IDLE and DONE: hold everything, result stays visible
                end
            endcase
        end
    end

    // Status outputs depend on the state register only
    assign busy_o      = (r_state == S_LOAD) || (r_state == S_CALC);
    assign done_o      = (r_state == S_DONE);
    assign fsm_state_o = r_state;
    assign result_o    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_controle_multiplicador.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_multiplicador
//  Description : Directed self-checking bench for controle_multiplicador
//                (default build, WIDTH=4). Expected values are hand computed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_multiplicador;

    localparam int c_W = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [c_W-1:0]    a;
    logic [c_W-1:0]    b;
    logic [2*c_W-1:0]  result;
    logic              busy;
    logic              done;
    logic [1:0]        fsm_state;

    int checks;
    int errors;

    controle_multiplicador #(.WIDTH(c_W)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .A_i         (a),
        .B_i         (b),
        .result_o    (result),
        .busy_o      (busy),
        .done_o      (done),
        .fsm_state_o (fsm_state)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge; sample and drive 1 ns later, away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain run; 1: change A/B to 15 in CALC; 2: drop start in CALC
    task automatic run(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic [7:0] exp, input int mode);
        int lat;
        a     = va;
        b     = vb;
        start = 1'b1;
        lat   = 0;
        do begin
            tick();
            lat++;
            if (mode == 1 && lat == 2) begin
                a = 4'd15;
                b = 4'd15;
            end
            if (mode == 2 && lat == 3) start = 1'b0;
            if (lat == 1) check({tag, "_load_state"}, 32'(fsm_state), 32'd1);
            if (lat >= 1 && lat <= 5) check({tag, "_busy"}, 32'(busy), 32'd1);
        end while (!done && lat < 30);
        check({tag, "_latency"}, 32'(lat), 32'd6);
        check({tag, "_result"},  32'(result), 32'(exp));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        start = 1'b0;
        tick();
        check({tag, "_idle_state"}, 32'(fsm_state), 32'd0);
        check({tag, "_result_held"}, 32'(result), 32'(exp));
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        tick();
        tick();
        check("rst_state",  32'(fsm_state), 32'd0);
        check("rst_result", 32'(result),    32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        rst = 1'b0;
        tick();
        check("idle_hold", 32'(fsm_state), 32'd0);

        run("m3x5",   4'd3,  4'd5,  8'd15,  0);
        run("m15x15", 4'd15, 4'd15, 8'd225, 0);
        run("m9x0",   4'd9,  4'd0,  8'd0,   0);
        run("m7x1",   4'd7,  4'd1,  8'd7,   0);
        run("m6x4chg", 4'd6, 4'd4,  8'd24,  1);
        run("m5x3drop", 4'd5, 4'd3, 8'd15,  2);

        // DONE hold with start high for 10 cycles, then release
        a = 4'd12; b = 4'd11; start = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 30);
        check("hold_result", 32'(result), 32'd132);
        a = 4'd1; b = 4'd1;
        for (int i = 0; i < 10; i++) tick();
        check("hold_state",  32'(fsm_state), 32'd3);
        check("hold_done",   32'(done),      32'd1);
        check("hold_result_after", 32'(result), 32'd132);
        start = 1'b0;
        tick();
        check("hold_release_state", 32'(fsm_state), 32'd0);
        check("hold_release_result", 32'(result), 32'd132);

        // Reset during the second CALC cycle, start kept high
        a = 4'd10; b = 4'd13; start = 1'b1;
        tick();   // IDLE -> LOAD
        tick();   // LOAD -> CALC
        tick();   // first CALC iteration
        check("midrst_in_calc", 32'(fsm_state), 32'd2);
        rst = 1'b1;
        tick();
        check("midrst_state",  32'(fsm_state), 32'd0);
        check("midrst_result", 32'(result),    32'd0);
        check("midrst_busy",   32'(busy),      32'd0);
        rst = 1'b0;
        a = 4'd2; b = 4'd7;
        run("post_rst", 4'd2, 4'd7, 8'd14, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
